// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// IF_ALIGN_CHECK_EN adds a misalign flag to every queued entry.
package instr_fetch_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_e;

`ifdef IF_ALIGN_CHECK_EN
    typedef struct packed {
        logic        misalign;
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
`else
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
`endif

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO with push/pop/flush, count and flags.
// A flush may coincide with a push; the pushed word becomes the sole entry.
module fetch_queue #(
    parameter int               DEPTH      = 2,
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int        PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [PW:0]      count_q;
    logic             do_pop, do_push;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

    // NOTE: the storage is tiny, so it is reset like any other flop; this pins the head
    // output to RESET_DATA straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_DATA;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= PW'(push_i);
            count_q  <= (PW+1)'(push_i);
            if (push_i) mem_q[0] <= push_data_i;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, single-outstanding imem req/ack master and 2-entry decode queue.
// Optional feature macro: IF_ALIGN_CHECK_EN (misaligned redirect yields a flagged nop, then halts).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        if_misalign
`endif
);

    localparam int             CW          = $clog2(QDEPTH) + 1;
    localparam int             EW          = $bits(fetch_entry_t);
    localparam logic [EW-1:0]  RESET_ENTRY = EW'({INSTR_NOP, RESET_PC});

    fetch_state_e   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    drop_addr_q, drop_addr_d;
    logic           halt_q, halt_d;
    logic           q_push, q_pop, q_flush, q_full, q_empty;
    logic [CW-1:0]  q_count;
    fetch_entry_t   push_entry, head_entry;
    logic [31:0]    redirect_tgt;
    logic           room_after_push;
    logic           outstanding_after;

`ifdef IF_ALIGN_CHECK_EN
    assign redirect_tgt = redirect_pc;
`else
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign q_pop           = if_valid && if_ready;
    assign room_after_push = (int'(q_count) + 1 - int'(q_pop)) < QDEPTH;

    // NOTE: every output of this block gets a default before any branch, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        drop_addr_d       = drop_addr_q;
        halt_d            = halt_q;
        q_push            = 1'b0;
        q_flush           = 1'b0;
        outstanding_after = 1'b0;
        push_entry        = '0;
        push_entry.instr  = imem_rdata;
        push_entry.pc     = pc_q;

        unique case (state_q)
            FETCH_IDLE: if (!halt_q && !q_full) state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (imem_ack) begin
                    q_push  = 1'b1;
                    pc_d    = pc_next(pc_q);
                    state_d = room_after_push ? FETCH_REQ : FETCH_IDLE;
                end
            end
            FETCH_DROP: if (imem_ack) state_d = halt_q ? FETCH_IDLE : FETCH_REQ;
            default:    state_d = FETCH_IDLE;
        endcase

        // Redirect overrides everything; an open handshake must still be allowed to finish.
        if (redirect) begin
            q_flush           = 1'b1;
            q_push            = 1'b0;
            pc_d              = redirect_tgt;
            halt_d            = 1'b0;
            outstanding_after = (state_q != FETCH_IDLE) && !imem_ack;
            if (outstanding_after) begin
                state_d = FETCH_DROP;
                if (state_q == FETCH_REQ) drop_addr_d = pc_q;
            end else begin
                state_d = FETCH_REQ;
            end
`ifdef IF_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                q_push              = 1'b1;
                push_entry.misalign = 1'b1;
                push_entry.instr    = INSTR_NOP;
                push_entry.pc       = redirect_pc;
                halt_d              = 1'b1;
                if (!outstanding_after) state_d = FETCH_IDLE;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            halt_q      <= halt_d;
        end
    end

    fetch_queue #(
        .DEPTH      (QDEPTH),
        .WIDTH      (EW),
        .RESET_DATA (RESET_ENTRY)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (q_push),
        .push_data_i (push_entry),
        .pop_i       (q_pop),
        .flush_i     (q_flush),
        .head_o      (head_entry),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    assign imem_req  = (state_q != FETCH_IDLE);
    assign imem_addr = (state_q == FETCH_DROP) ? drop_addr_q : pc_q;
    assign if_valid  = !q_empty;
    assign if_instr  = head_entry.instr;
    assign if_pc     = head_entry.pc;
    assign if_pc4    = pc_next(head_entry.pc);
`ifdef IF_ALIGN_CHECK_EN
    assign if_misalign = head_entry.misalign;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .if_misalign (if_misalign)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: what decode should see, and whether a request is open.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          mis;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_drop;
    bit          m_halt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tgt_of(input logic [31:0] a);
`ifdef IF_ALIGN_CHECK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc   = RESET_PC;
        m_addr = RESET_PC;
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic model_step();
        int          n;
        bit          pop;
        bit          open_after;
        logic [31:0] tgt;
        n   = m_q.size();
        pop = (n > 0) && if_ready;
        if (redirect) begin
            tgt = tgt_of(redirect_pc);
            m_q.delete();
            m_pc       = tgt;
            m_halt     = 1'b0;
            open_after = m_busy && !imem_ack;
            if (open_after) begin
                m_drop = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_drop = 1'b0;
                m_addr = tgt;
            end
`ifdef IF_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                m_q.push_back('{instr: 32'h0, pc: redirect_pc, mis: 1'b1});
                m_halt = 1'b1;
                if (!open_after) m_busy = 1'b0;
            end
`endif
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy && imem_ack) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_busy = !m_halt;
                    m_addr = m_pc;
                end else begin
                    m_q.push_back('{instr: imem_rdata, pc: m_pc, mis: 1'b0});
                    m_pc   = m_pc + 32'd4;
                    m_addr = m_pc;
                    m_busy = m_q.size() < QDEPTH;
                end
            end else if (!m_busy && !m_halt && n < QDEPTH) begin
                m_busy = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    // Single per-cycle comparison point, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("req", imem_req, m_busy);
            if (m_busy) check("addr", imem_addr, m_addr);
            check("valid", if_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                check("instr", if_instr, m_q[0].instr);
                check("pc", if_pc, m_q[0].pc);
                check("pc4", if_pc4, m_q[0].pc + 32'd4);
`ifdef IF_ALIGN_CHECK_EN
                check("misalign", if_misalign, m_q[0].mis);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #2;
    endtask

    task automatic drive(input bit rd, input logic [31:0] rpc, input bit ack, input bit rdy);
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        if_ready    = rdy;
        imem_rdata  = ack ? (imem_addr ^ 32'hA5A5_0000) : $urandom();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        if_ready    = 1'b0;
        imem_rdata  = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0000_3000);
        check("rst_pc4", if_pc4, 32'h0000_3004);
        chk_en = 1'b1;

        // Ack tied to req, decode always ready: one instruction per cycle.
        drive(0, 0, imem_req, 1); tick();
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0000_3000);
        drive(0, 0, imem_req, 1); tick();
        check("stream_pc0", if_pc, 32'h0000_3000);
        check("stream_instr0", if_instr, 32'hA5A5_3000);
        check("stream_pc4_0", if_pc4, 32'h0000_3004);
        drive(0, 0, imem_req, 1); tick();
        check("stream_pc1", if_pc, 32'h0000_3004);
        drive(0, 0, imem_req, 1); tick();
        check("stream_pc2", if_pc, 32'h0000_3008);

        // Decode stalls: queue fills to two entries, fetch stops, then drains in order.
        repeat (5) begin
            drive(0, 0, imem_req, 0); tick();
        end
        check("stall_req", imem_req, 1'b0);
        check("stall_head", if_pc, 32'h0000_3008);
        check("stall_count", dut.u_queue.count_o, 2);
        check("stall_model_count", m_q.size(), 2);
        drive(0, 0, imem_req, 1); tick();
        check("drain_head1", if_pc, 32'h0000_300C);
        drive(0, 0, imem_req, 1); tick();
        check("drain_empty", if_valid, 1'b0);
        check("refetch_addr", imem_addr, 32'h0000_3010);
        drive(0, 0, imem_req, 1); tick();
        check("refetch_head", if_pc, 32'h0000_3010);

        // Redirect while a slow request is open: the old word is dropped.
        do_reset();
        drive(0, 0, 0, 1); tick();
        drive(1, 32'h0000_3100, 0, 1); tick();
        check("drop_req", imem_req, 1'b1);
        check("drop_addr_held", imem_addr, 32'h0000_3000);
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 1, 1); tick();
        check("drop_no_push", if_valid, 1'b0);
        check("drop_new_addr", imem_addr, 32'h0000_3100);
        drive(0, 0, 1, 1); tick();
        check("redir_pc", if_pc, 32'h0000_3100);
        check("redir_instr", if_instr, 32'hA5A5_3100);

        // Redirect together with ack and pop: everything discarded.
        drive(1, 32'h0000_3200, 1, 1); tick();
        check("flush_valid", if_valid, 1'b0);
        check("flush_model_empty", m_q.size(), 0);
        check("flush_addr", imem_addr, 32'h0000_3200);
        drive(0, 0, 1, 1); tick();
        check("flush_next_pc", if_pc, 32'h0000_3200);

        // PC wrap at the top of the address space.
        drive(1, 32'hFFFF_FFFC, 1, 1); tick();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 1, 1); tick();
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_pc4, 32'h0000_0000);
        check("wrap_next_addr", imem_addr, 32'h0000_0000);

        // Misaligned redirect target.
        drive(1, 32'h0000_3002, 1, 0); tick();
`ifdef IF_ALIGN_CHECK_EN
        check("mis_valid", if_valid, 1'b1);
        check("mis_pc", if_pc, 32'h0000_3002);
        check("mis_instr", if_instr, 32'h0);
        check("mis_flag", if_misalign, 1'b1);
        check("mis_no_req", imem_req, 1'b0);
`else
        check("align_valid", if_valid, 1'b0);
        check("align_addr", imem_addr, 32'h0000_3000);
`endif
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 1); tick();
`ifdef IF_ALIGN_CHECK_EN
        check("halt_req", imem_req, 1'b0);
        check("halt_valid", if_valid, 1'b0);
`else
        check("align_req", imem_req, 1'b1);
`endif

        // Reset in the middle of a request; a late ack afterwards is ignored.
        drive(1, 32'h0000_3400, 0, 1); tick();
        check("pre_rst_req", imem_req, 1'b1);
        rst      = 1'b1;
        imem_ack = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        drive(0, 0, 1, 1); tick();
        check("late_ack_valid", if_valid, 1'b0);
        check("late_ack_addr", imem_addr, 32'h0000_3000);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int          mode;
            bit          rd;
            bit          ack;
            logic [31:0] rpc;
            mode = (i / 250) % 3;
            rd   = ($urandom_range(0, 15) == 0);
            rpc  = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            case (mode)
                0:       ack = imem_req;
                1:       ack = ($urandom_range(0, 1) == 1);
                default: ack = ($urandom_range(0, 3) == 0);
            endcase
            drive(rd, rpc, ack, $urandom_range(0, 3) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
